// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, cmd codes,
// datapath mux selects, condition codes and the registered control bundle.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } stateT;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010,
                           COND_CC = 4'b0011, COND_MI = 4'b0100, COND_PL = 4'b0101,
                           COND_VS = 4'b0110, COND_VC = 4'b0111, COND_HI = 4'b1000,
                           COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
                           COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110,
                           COND_NV = 4'b1111;

    typedef struct packed {
        logic       pcWrite;
        logic       adrSrc;
        logic       memW;
        logic       irWrite;
        logic       regW;
        logic [1:0] resultSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] immSrc;
        logic [1:0] regSrc;
        logic [1:0] aluControl;
    } ctrlT;

    function automatic logic [1:0] aluDecode(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of cond against NZCV flags.
module cond_check
    import multicycle_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condEx
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        // NOTE: default assignment first so every path drives condEx -- no latch.
        condEx = 1'b0;
        case (cond)
            COND_EQ: condEx = z;
            COND_NE: condEx = ~z;
            COND_CS: condEx = c;
            COND_CC: condEx = ~c;
            COND_MI: condEx = n;
            COND_PL: condEx = ~n;
            COND_VS: condEx = v;
            COND_VC: condEx = ~v;
            COND_HI: condEx = c & ~z;
            COND_LS: condEx = ~c | z;
            COND_GE: condEx = (n == v);
            COND_LT: condEx = (n != v);
            COND_GT: condEx = ~z & (n == v);
            COND_LE: condEx = z | (n != v);
            COND_AL: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM with registered Moore outputs and internal NZCV.
// Optional macro MEM_READY_EN adds mem_ready stalls in FETCH, MEMRD and MEMWR.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int FLAG_W   = 4,
    parameter int ALUCTL_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef MEM_READY_EN
    input  logic                mem_ready,
`endif
    input  logic [3:0]          cond,
    input  logic [1:0]          op,
    input  logic [5:0]          funct,
    input  logic [3:0]          rd,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_w,
    output logic                ir_write,
    output logic                reg_w,
    output logic [1:0]          result_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [1:0]          reg_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [FLAG_W-1:0]   flags_q
);
    stateT state, nextState;
    ctrlT  ctrlQ, ctrlD;
    logic  condEx, memReady, fetchGo;

    logic [3:0] cmd;
    logic       isCmp, setFlags, isArith, execState;

    assign cmd       = funct[4:1];
    assign isCmp     = (cmd == CMD_CMP);
    assign setFlags  = funct[0] | isCmp;
    assign isArith   = (cmd == CMD_ADD) | (cmd == CMD_SUB) | isCmp;
    assign execState = (state == EXECR) | (state == EXECI);

`ifdef MEM_READY_EN
    assign memReady = mem_ready;
`else
    assign memReady = 1'b1;
`endif

    cond_check u_cond_check (
        .cond   (cond),
        .flags  (flags_q[3:0]),
        .condEx (condEx)
    );

    always_comb begin
        nextState = state;
        case (state)
            RST:          nextState = FETCH;
            FETCH:        nextState = memReady ? DECODE : FETCH;
            DECODE: begin
                if (!condEx || op == OP_NOP) nextState = FETCH;
                else if (op == OP_MEM)       nextState = MEMADR;
                else if (op == OP_BR)        nextState = BRANCH;
                else                         nextState = funct[5] ? EXECI : EXECR;
            end
            MEMADR:       nextState = funct[0] ? MEMRD : MEMWR;
            MEMRD:        nextState = memReady ? MEMWB : MEMRD;
            MEMWR:        nextState = memReady ? FETCH : MEMWR;
            EXECR, EXECI: nextState = isCmp ? FETCH : ALUWB;
            MEMWB, ALUWB, BRANCH: nextState = FETCH;
            default:      nextState = RST;
        endcase
    end

    // Outputs are decoded for the state being entered, so they register in step with it.
    always_comb begin
        ctrlD = '0;
        case (nextState)
            FETCH: begin
                ctrlD.irWrite    = 1'b1;
                ctrlD.pcWrite    = 1'b1;
                ctrlD.aluSrcA    = 1'b1;
                ctrlD.aluSrcB    = SRCB_FOUR;
                ctrlD.aluControl = ALU_ADD;
                ctrlD.resultSrc  = RES_ALU;
            end
            DECODE: begin
                ctrlD.aluSrcA    = 1'b1;
                ctrlD.aluSrcB    = SRCB_FOUR;
                ctrlD.aluControl = ALU_ADD;
                ctrlD.resultSrc  = RES_ALU;
            end
            MEMADR: begin
                ctrlD.aluSrcB    = SRCB_IMM;
                ctrlD.immSrc     = IMM_MEM;
                ctrlD.aluControl = ALU_ADD;
            end
            MEMRD: ctrlD.adrSrc = 1'b1;
            MEMWB: begin
                ctrlD.regW      = 1'b1;
                ctrlD.resultSrc = RES_DATA;
                ctrlD.pcWrite   = (rd == 4'hF);
            end
            MEMWR: begin
                ctrlD.adrSrc = 1'b1;
                ctrlD.memW   = 1'b1;
                ctrlD.regSrc = 2'b10;
            end
            EXECR: begin
                ctrlD.aluSrcB    = SRCB_REG;
                ctrlD.aluControl = aluDecode(cmd);
            end
            EXECI: begin
                ctrlD.aluSrcB    = SRCB_IMM;
                ctrlD.immSrc     = IMM_DP;
                ctrlD.aluControl = aluDecode(cmd);
            end
            ALUWB: begin
                ctrlD.regW      = 1'b1;
                ctrlD.resultSrc = RES_ALUOUT;
                ctrlD.pcWrite   = (rd == 4'hF);
            end
            BRANCH: begin
                ctrlD.aluSrcA    = 1'b0;
                ctrlD.regSrc     = 2'b01;
                ctrlD.aluSrcB    = SRCB_IMM;
                ctrlD.immSrc     = IMM_BR;
                ctrlD.aluControl = ALU_ADD;
                ctrlD.resultSrc  = RES_ALU;
                ctrlD.pcWrite    = 1'b1;
            end
            default: ctrlD = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (!rst_n) begin
            state   <= RST;
            ctrlQ   <= '0;
            flags_q <= '0;
        end else begin
            state <= nextState;
            ctrlQ <= ctrlD;
            if (execState && setFlags) begin
                flags_q[3:2] <= alu_flags[3:2];
                if (isArith) flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    // PC and IR loads only commit in the FETCH cycle where memory is ready.
    assign fetchGo     = (state != FETCH) | memReady;
    assign pc_write    = ctrlQ.pcWrite & fetchGo;
    assign ir_write    = ctrlQ.irWrite & fetchGo;
    assign adr_src     = ctrlQ.adrSrc;
    assign mem_w       = ctrlQ.memW;
    assign reg_w       = ctrlQ.regW;
    assign result_src  = ctrlQ.resultSrc;
    assign alu_src_a   = ctrlQ.aluSrcA;
    assign alu_src_b   = ctrlQ.aluSrcB;
    assign imm_src     = ctrlQ.immSrc;
    assign reg_src     = ctrlQ.regSrc;
    assign alu_control = ALUCTL_W'(ctrlQ.aluControl);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: an instruction-level model pushes
// per-cycle expected control vectors; a negedge monitor pops and compares.
module tb_multicycle_controller;

    logic       clk, rst_n, memReady;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pc_write, adr_src, mem_w, ir_write, reg_w, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_control;
    logic [3:0] flags_q;

    typedef struct packed {
        logic       pcW;
        logic       adr;
        logic       memW;
        logic       irW;
        logic       regW;
        logic [1:0] res;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] imm;
        logic [1:0] regSrc;
        logic [1:0] alu;
        logic [3:0] flags;
    } vecT;

    typedef enum {P_RST, P_FETCH, P_FSTALL, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB,
                  P_MEMWR, P_EXECR, P_EXECI, P_ALUWB, P_BRANCH} phaseT;

    vecT        expQ[$];
    string      nameQ[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] modelFlags;
    vecT        actVec;

    assign actVec = {pc_write, adr_src, mem_w, ir_write, reg_w, result_src, alu_src_a,
                     alu_src_b, imm_src, reg_src, alu_control, flags_q};

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MEM_READY_EN
        .mem_ready   (memReady),
`endif
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .rd          (rd),
        .alu_flags   (alu_flags),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_w       (mem_w),
        .ir_write    (ir_write),
        .reg_w       (reg_w),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .reg_src     (reg_src),
        .alu_control (alu_control),
        .flags_q     (flags_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input vecT act, input vecT exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (pcW adr memW irW regW res srcA srcB imm regSrc alu nzcv)",
                     name, act, exp);
        end
    endtask

    function automatic logic [1:0] aluOp(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            4'b1010: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic vecT expVec(input phaseT ph, input logic [3:0] r,
                                   input logic [5:0] fn, input logic [3:0] fl);
        vecT v;
        v = '0;
        v.flags = fl;
        case (ph)
            P_FETCH:  begin v.irW = 1; v.pcW = 1; v.srcA = 1; v.srcB = 2'b10; v.res = 2'b10; end
            P_FSTALL: begin v.srcA = 1; v.srcB = 2'b10; v.res = 2'b10; end
            P_DECODE: begin v.srcA = 1; v.srcB = 2'b10; v.res = 2'b10; end
            P_MEMADR: begin v.srcB = 2'b01; v.imm = 2'b01; end
            P_MEMRD:  v.adr = 1;
            P_MEMWB:  begin v.regW = 1; v.res = 2'b01; v.pcW = (r == 4'hF); end
            P_MEMWR:  begin v.adr = 1; v.memW = 1; v.regSrc = 2'b10; end
            P_EXECR:  v.alu = aluOp(fn[4:1]);
            P_EXECI:  begin v.srcB = 2'b01; v.alu = aluOp(fn[4:1]); end
            P_ALUWB:  begin v.regW = 1; v.pcW = (r == 4'hF); end
            P_BRANCH: begin v.regSrc = 2'b01; v.srcB = 2'b01; v.imm = 2'b10; v.res = 2'b10; v.pcW = 1; end
            default:  v = '0;
        endcase
        return v;
    endfunction

    // Entered at posedge+1 of the instruction's first FETCH cycle; leaves at the
    // next instruction's FETCH (or, with cut>0, inside the cut-th cycle).
    task automatic runInstr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                            input logic [3:0] r, input logic [3:0] af, input int stall,
                            input int cut);
        phaseT ph[$];
        logic [3:0] cmd;
        int waits;
        cmd = fn[4:1];
        for (int i = 0; i < stall; i++) ph.push_back(P_FSTALL);
        ph.push_back(P_FETCH);
        ph.push_back(P_DECODE);
        if (condPass(c, modelFlags) && o != 2'b11) begin
            case (o)
                2'b01: begin
                    ph.push_back(P_MEMADR);
                    if (fn[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                    else ph.push_back(P_MEMWR);
                end
                2'b10: ph.push_back(P_BRANCH);
                default: begin
                    ph.push_back(fn[5] ? P_EXECI : P_EXECR);
                    if (cmd != 4'b1010) ph.push_back(P_ALUWB);
                end
            endcase
        end
        if (cut > 0) while (ph.size() > cut) void'(ph.pop_back());
        for (int i = 0; i < ph.size(); i++) begin
            expQ.push_back(expVec(ph[i], r, fn, modelFlags));
            nameQ.push_back(ph[i].name());
            if (ph[i] == P_EXECR || ph[i] == P_EXECI) begin
                if (fn[0] || cmd == 4'b1010) modelFlags[3:2] = af[3:2];
                if ((fn[0] || cmd == 4'b1010) && (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010))
                    modelFlags[1:0] = af[1:0];
            end
        end
        cond = c; op = o; funct = fn; rd = r; alu_flags = af;
        memReady = (stall == 0);
        waits = (cut > 0) ? ph.size() - 1 : ph.size();
        for (int i = 0; i < waits; i++) begin
            if (i == stall) memReady = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        check("async_reset", actVec, '0);
        modelFlags = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expQ.push_back(expVec(P_RST, 4'h0, 6'h0, 4'h0));
        nameQ.push_back("RST");
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) check(nameQ.pop_front(), actVec, expQ.pop_front());
        end
    end

    initial begin
        rst_n = 1'b1; memReady = 1'b1; modelFlags = '0;
        cond = 4'hE; op = 2'b11; funct = '0; rd = '0; alu_flags = '0;
        #2;
        doReset();

        runInstr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0, 0, 0);   // ADD imm
        runInstr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0110, 0, 0); // SUBS reg
        runInstr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100, 0, 0); // CMP, Z=1
        runInstr(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 0, 0);    // BEQ taken
        runInstr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0000, 0, 0); // CMP, Z=0
        runInstr(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 0, 0);    // BEQ skipped
        runInstr(4'hE, 2'b01, 6'b011001, 4'hF, 4'h0, 0, 0);    // LDR to PC
        runInstr(4'hE, 2'b01, 6'b011000, 4'h3, 4'h0, 0, 0);    // STR
        runInstr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b1111, 0, 0); // CMP sets NZCV
        runInstr(4'hE, 2'b01, 6'b011000, 4'h3, 4'h0, 0, 4);    // STR cut in MEMWR
        @(negedge clk);
        #2;
        doReset();

`ifdef MEM_READY_EN
        runInstr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0, 3, 0);
`endif

        for (int k = 0; k < 80; k++) begin
            logic [3:0] c, r;
            int stall;
            c = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            stall = 0;
`ifdef MEM_READY_EN
            stall = $urandom_range(0, 2);
`endif
            runInstr(c, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), r,
                     4'($urandom_range(0, 15)), stall, 0);
        end

        repeat (2) @(negedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
